// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between the width-converting FIFO and the UART transmitter.
// The transmitter is the master: it issues pops, and the FIFO answers with data and an empty flag.
interface fifo_uart_tx_if;
    logic       buf_empty;
    logic [7:0] buf_out;
    logic       rd_en;

    modport master (
        input  buf_empty,
        input  buf_out,
        output rd_en
    );

    modport slave (
        output buf_empty,
        output buf_out,
        input  rd_en
    );
endinterface

// File: rtl/fifo_uart_tx.sv
// 8N1 UART transmitter that pops bytes from the FIFO read port and drives the external tx pin.
// tx is registered so the pin never glitches; the other outputs are decoded from the state register.
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic                  clk,
    input  logic                  rst,
    fifo_uart_tx_if.master        bus,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] FETCH = 3'd1;
    localparam logic [2:0] LOAD  = 3'd2;
    localparam logic [2:0] START = 3'd3;
    localparam logic [2:0] DATA  = 3'd4;
    localparam logic [2:0] STOP  = 3'd5;

    logic [2:0]        state;
    logic [2:0]        state_n;
    logic [BAUD_W-1:0] baud_cnt;
    logic [BAUD_W-1:0] baud_cnt_n;
    logic [2:0]        bit_idx;
    logic [2:0]        bit_idx_n;
    logic [7:0]        shift_reg;
    logic [7:0]        shift_reg_n;
    logic              tx_n;
    logic              baud_last;

    assign baud_last = (baud_cnt == BAUD_LAST);

    always_comb begin
        state_n     = state;
        baud_cnt_n  = baud_cnt;
        bit_idx_n   = bit_idx;
        shift_reg_n = shift_reg;
        case (state)
            IDLE: begin
                if (!bus.buf_empty) begin
                    state_n = FETCH;
                end
            end
            FETCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                // The FIFO presents the popped byte one cycle after rd_en.
                shift_reg_n = bus.buf_out;
                baud_cnt_n  = '0;
                state_n     = START;
            end
            START: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    bit_idx_n  = 3'd0;
                    state_n    = DATA;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            DATA: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_cnt_n = '0;
                    state_n    = IDLE;
                end else begin
                    baud_cnt_n = baud_cnt + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Line level is computed from the upcoming state so the registered pin lines up with it.
    always_comb begin
        tx_n = 1'b1;
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_reg_n[bit_idx_n];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            baud_cnt  <= '0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'h00;
            tx        <= 1'b1;
        end else begin
            state     <= state_n;
            baud_cnt  <= baud_cnt_n;
            bit_idx   <= bit_idx_n;
            shift_reg <= shift_reg_n;
            tx        <= tx_n;
        end
    end

    assign bus.rd_en = (state == FETCH);
    assign busy      = (state != IDLE);
    assign tx_done   = (state == STOP) && baud_last;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with CLKS_PER_BIT=4 and a small behavioural FIFO on the read port.
module tb_fifo_uart_tx;

    localparam int CPB = 4;
    localparam int LOG_N = 2048;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic busy;
    logic tx_done;

    fifo_uart_tx_if bus();

    fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.master),
        .tx      (tx),
        .busy    (busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Registered-read FIFO model: data appears on buf_out the cycle after rd_en.
    logic [7:0] fifo_mem [0:15];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic [7:0] buf_out_r = 8'h00;
    logic       toggle_en = 1'b0;
    logic       toggle_val = 1'b1;

    assign bus.buf_empty = toggle_en ? toggle_val : (wr_ptr == rd_ptr);
    assign bus.buf_out   = buf_out_r;

    always @(posedge clk) begin
        if (bus.rd_en && (wr_ptr != rd_ptr)) begin
            buf_out_r <= fifo_mem[rd_ptr % 16];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic tx_log   [0:LOG_N-1];
    logic rd_log   [0:LOG_N-1];
    logic busy_log [0:LOG_N-1];
    logic done_log [0:LOG_N-1];

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            tx_log[cyc]   = tx;
            rd_log[cyc]   = bus.rd_en;
            busy_log[cyc] = busy;
            done_log[cyc] = tx_done;
        end
    end

    int tests = 0;
    int fails = 0;

    // Expected pin behaviour relative to the cycle T in which buf_empty first reads 0.
    function automatic logic exp_tx(input logic [7:0] b, input int off);
        if (off >= 3 && off <= 6) return 1'b0;
        if (off >= 7 && off <= 38) return b[(off - 7) / 4];
        return 1'b1;
    endfunction

    function automatic logic exp_busy(input int off);
        return (off >= 1 && off <= 42);
    endfunction

    task automatic push(input logic [7:0] b);
        fifo_mem[wr_ptr % 16] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        wait_cycles(3);
        tests++;
        if (tx !== 1'b1 || bus.rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
            fails++;
            $display("[TB] FAIL reset_hold tx=%b rd_en=%b busy=%b tx_done=%b, want 1 0 0 0",
                     tx, bus.rd_en, busy, tx_done);
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            tests++;
            if (tx !== 1'b1 || bus.rd_en !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0) begin
                fails++;
                $display("[TB] FAIL reset_idle cycle %0d tx=%b rd_en=%b busy=%b tx_done=%b, want 1 0 0 0",
                         i, tx, bus.rd_en, busy, tx_done);
            end
        end
    endtask

    task automatic test_single_a5();
        int t;
        t = cyc;
        push(8'hA5);
        wait_cycles(46);
        for (int k = 0; k < 45; k++) begin
            tests++;
            if (tx_log[t+k] !== exp_tx(8'hA5, k)) begin
                fails++;
                $display("[TB] FAIL a5_tx T+%0d got %b want %b", k, tx_log[t+k], exp_tx(8'hA5, k));
            end
            tests++;
            if (rd_log[t+k] !== (k == 1)) begin
                fails++;
                $display("[TB] FAIL a5_rd_en T+%0d got %b want %b", k, rd_log[t+k], (k == 1));
            end
            tests++;
            if (busy_log[t+k] !== exp_busy(k)) begin
                fails++;
                $display("[TB] FAIL a5_busy T+%0d got %b want %b", k, busy_log[t+k], exp_busy(k));
            end
            tests++;
            if (done_log[t+k] !== (k == 42)) begin
                fails++;
                $display("[TB] FAIL a5_tx_done T+%0d got %b want %b", k, done_log[t+k], (k == 42));
            end
        end
    endtask

    task automatic test_back_to_back();
        int t;
        int rd_cnt;
        int gap;
        logic [7:0] b1;
        logic [7:0] b2;
        t = cyc;
        push(8'h11);
        push(8'h22);
        wait_cycles(96);
        for (int i = 0; i < 8; i++) begin
            b1[i] = tx_log[t + 7 + 4*i + 2];
            b2[i] = tx_log[t + 43 + 7 + 4*i + 2];
        end
        tests++;
        if (b1 !== 8'h11) begin
            fails++;
            $display("[TB] FAIL b2b_first_byte got %h want 11", b1);
        end
        tests++;
        if (b2 !== 8'h22) begin
            fails++;
            $display("[TB] FAIL b2b_second_byte got %h want 22", b2);
        end
        gap = 0;
        while (gap < 40 && tx_log[t + 39 + gap] === 1'b1) gap++;
        tests++;
        if (gap != 7) begin
            fails++;
            $display("[TB] FAIL b2b_gap high cycles %0d want 7", gap);
        end
        rd_cnt = 0;
        for (int k = 0; k < 95; k++) if (rd_log[t+k] === 1'b1) rd_cnt++;
        tests++;
        if (rd_cnt != 2) begin
            fails++;
            $display("[TB] FAIL b2b_rd_pulses got %0d want 2", rd_cnt);
        end
        tests++;
        if (done_log[t+42] !== 1'b1 || done_log[t+85] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_tx_done got %b,%b want 1,1", done_log[t+42], done_log[t+85]);
        end
    endtask

    task automatic test_extremes();
        int t;
        int run;
        t = cyc;
        push(8'h00);
        wait_cycles(46);
        run = 0;
        while (run < 60 && tx_log[t + 3 + run] === 1'b0) run++;
        tests++;
        if (run != 36) begin
            fails++;
            $display("[TB] FAIL zero_low_run got %0d want 36", run);
        end
        tests++;
        if (tx_log[t+39] !== 1'b1 || done_log[t+42] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL zero_stop tx=%b tx_done=%b want 1 1", tx_log[t+39], done_log[t+42]);
        end
        t = cyc;
        push(8'hFF);
        wait_cycles(46);
        run = 0;
        while (run < 60 && tx_log[t + 3 + run] === 1'b0) run++;
        tests++;
        if (run != 4) begin
            fails++;
            $display("[TB] FAIL ones_start_run got %0d want 4", run);
        end
        run = 0;
        for (int k = 7; k <= 42; k++) if (tx_log[t+k] === 1'b1) run++;
        tests++;
        if (run != 36 || done_log[t+42] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL ones_high high=%0d tx_done=%b want 36 1", run, done_log[t+42]);
        end
    endtask

    task automatic test_empty_toggle();
        int t;
        t = cyc;
        push(8'h3C);
        wait_cycles(2);
        toggle_en = 1'b1;
        for (int i = 0; i < 38; i++) begin
            toggle_val = ~toggle_val;
            @(negedge clk);
        end
        toggle_en = 1'b0;
        wait_cycles(10);
        for (int k = 0; k < 48; k++) begin
            tests++;
            if (rd_log[t+k] !== (k == 1)) begin
                fails++;
                $display("[TB] FAIL toggle_rd_en T+%0d got %b want %b", k, rd_log[t+k], (k == 1));
            end
            tests++;
            if (tx_log[t+k] !== exp_tx(8'h3C, k)) begin
                fails++;
                $display("[TB] FAIL toggle_tx T+%0d got %b want %b", k, tx_log[t+k], exp_tx(8'h3C, k));
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int t;
        int tn;
        t = cyc;
        push(8'h5A);
        wait_cycles(20);
        tests++;
        if (tx_log[t+19] !== 1'b1) begin
            fails++;
            $display("[TB] FAIL mid_bit3 got %b want 1", tx_log[t+19]);
        end
        rst = 1'b1;
        push(8'hC3);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if (tx !== 1'b1 || busy !== 1'b0 || bus.rd_en !== 1'b0) begin
            fails++;
            $display("[TB] FAIL mid_reset_state tx=%b busy=%b rd_en=%b want 1 0 0", tx, busy, bus.rd_en);
        end
        tn = cyc;
        wait_cycles(46);
        for (int k = 0; k < 45; k++) begin
            tests++;
            if (tx_log[tn+k] !== exp_tx(8'hC3, k)) begin
                fails++;
                $display("[TB] FAIL restart_tx T+%0d got %b want %b", k, tx_log[tn+k], exp_tx(8'hC3, k));
            end
            tests++;
            if (rd_log[tn+k] !== (k == 1) || busy_log[tn+k] !== exp_busy(k)) begin
                fails++;
                $display("[TB] FAIL restart_ctrl T+%0d rd_en=%b busy=%b want %b %b",
                         k, rd_log[tn+k], busy_log[tn+k], (k == 1), exp_busy(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_extremes();
        test_empty_toggle();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

endmodule
